gon_collector: RTL and testbench
================================

GON_COLLECTOR -- requirements
Module: gon_collector

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH 64 (payload bits); ROW_TAG_WIDTH 4; COL_TAG_WIDTH 4; NUM_OF_ROWS 12; NUM_OF_COLS 14; GON_FIFO_DEPTH 16 (tag and data FIFO depth); TIMEOUT_CYCLES 256 (watchdog limit).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset: clk input 1 (clock); reset input 1 (async active-high reset).
REQ-003 Tag side ports SHALL be: row_tag input ROW_TAG_WIDTH; col_tag input COL_TAG_WIDTH; tags_wr_en input 1; tags_full output 1.
REQ-004 ID ports SHALL be: row_id input ROW_TAG_WIDTH per row [0:NUM_OF_ROWS-1]; col_id input COL_TAG_WIDTH per PE [0:NUM_OF_ROWS-1][0:NUM_OF_COLS-1].
REQ-005 PE side ports SHALL be: data_in input DATA_WIDTH per PE; enable_in input [0:NUM_OF_COLS-1] per row (PE valid); ready_out output [0:NUM_OF_COLS-1] per row (grant to PE).
REQ-006 Host side ports SHALL be: data_out output DATA_WIDTH; data_rd_en input 1; data_empty output 1; timeout_err output 1 (only with GON_TIMEOUT_EN).

Function
REQ-007 Tags SHALL be written as {col_tag,row_tag} into a tag FIFO; each tag names exactly one PE to be read.
REQ-008 FSM states SHALL be IDLE and WAIT; in IDLE with tag FIFO non-empty, the head tag SHALL be popped into tag_q and the FSM SHALL enter WAIT on the next cycle.
REQ-009 In WAIT, the selected PE SHALL be the one with row_id[r]==tag_q.row and col_id[r][c]==tag_q.col; on multiple matches, the lowest r, then the lowest c, SHALL win.
REQ-010 ready_out SHALL be 1 only for the selected PE, only in WAIT, and only while the data FIFO is not full; all other bits SHALL be 0.
REQ-011 A transfer SHALL occur when the selected PE's enable_in and ready_out are both 1; its data_in SHALL be pushed into the data FIFO in that same cycle.
REQ-012 On a transfer cycle, a non-empty tag FIFO SHALL pop the next tag into tag_q and WAIT SHALL be held (1 word/cycle throughput); an empty tag FIFO SHALL send the FSM to IDLE.
REQ-013 enable_in from unselected PEs SHALL be ignored and SHALL NOT be consumed.
REQ-014 Host reads SHALL pop the data FIFO on data_rd_en & ~data_empty; data_rd_en while empty SHALL have no effect.
REQ-015 tags_wr_en while tags_full SHALL be dropped and SHALL NOT corrupt FIFO contents.
REQ-016 Pushing and popping both FIFOs in the same cycle SHALL be legal at any occupancy, including full and empty.
REQ-017 Words SHALL reach data_out in tag-issue order.

Reset
REQ-018 Asserting reset SHALL, asynchronously: empty both FIFOs (tags_full=0, data_empty=1), put the FSM in IDLE, clear tag_q, force all ready_out to 0, and clear the watchdog counter and timeout_err.
REQ-019 Reset asserted mid-transfer SHALL discard the in-flight tag; no partial word SHALL be pushed.

Configuration
REQ-020 With macro GON_TIMEOUT_EN defined, a counter SHALL increment on each WAIT cycle that has no transfer and a non-full data FIFO, and SHALL clear on each transfer or on tag load.
REQ-021 With GON_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES-1 SHALL drop tag_q, pulse timeout_err high for 1 cycle, push no data, and apply the REQ-012 next-state rule.
REQ-022 Without GON_TIMEOUT_EN, the counter and the timeout_err port SHALL be absent, and WAIT SHALL persist until a transfer occurs.

Structure
REQ-023 The shared package noc_pkg SHALL hold the default widths, array dimensions, and the gon_state_t enum (IDLE, WAIT).
REQ-024 Both FIFOs SHALL be fifo_top instances; PE matching and the one-hot ready_out decode SHALL live in the sub-module gon_select.

Verification
REQ-025 Single read: tag (r=2,c=5), PE[2][5] drives enable_in with data 0xA5A5 -> ready_out[2][5] is high 2 cycles after the tag write; data_out=0xA5A5, data_empty=0.
REQ-026 Back-to-back: 4 tags to 4 PEs, all enable_in high -> one transfer per cycle and data order matches tag order.
REQ-027 Backpressure: data FIFO filled to 16 without host reads -> ready_out is all 0 and no drop occurs; one data_rd_en -> exactly one further transfer.
REQ-028 Multi-match: rows 3 and 7 both carry row_id 3 with col_id 4 -> only PE[3][c] with col_id 4 is granted.
REQ-029 Timeout (GON_TIMEOUT_EN): tag for a silent PE -> timeout_err pulses at WAIT cycle 256, the next tag is served, and data_empty stays 1.
REQ-030 Reset mid-WAIT: reset asserted while ready_out is high -> ready_out falls immediately, and the FIFOs are empty after release.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared defaults and types for the gather-on-network collector.
package noc_pkg;
   localparam int DEF_DATA_WIDTH     = 64;
   localparam int DEF_ROW_TAG_WIDTH  = 4;
   localparam int DEF_COL_TAG_WIDTH  = 4;
   localparam int DEF_NUM_OF_ROWS    = 12;
   localparam int DEF_NUM_OF_COLS    = 14;
   localparam int DEF_GON_FIFO_DEPTH = 16;
   localparam int DEF_TIMEOUT_CYCLES = 256;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } gon_state_t;
endpackage

// File: rtl/gon_collector_if.sv
// Tag, PE-array and host signals of the collector; timeout_err exists only with GON_TIMEOUT_EN.
interface gon_collector_if
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ROW_TAG_WIDTH = DEF_ROW_TAG_WIDTH,
   parameter int COL_TAG_WIDTH = DEF_COL_TAG_WIDTH,
   parameter int NUM_OF_ROWS   = DEF_NUM_OF_ROWS,
   parameter int NUM_OF_COLS   = DEF_NUM_OF_COLS
);
   logic [ROW_TAG_WIDTH-1:0] row_tag;
   logic [COL_TAG_WIDTH-1:0] col_tag;
   logic                     tags_wr_en;
   logic                     tags_full;
   logic [ROW_TAG_WIDTH-1:0] row_id    [0:NUM_OF_ROWS-1];
   logic [COL_TAG_WIDTH-1:0] col_id    [0:NUM_OF_ROWS-1][0:NUM_OF_COLS-1];
   logic [DATA_WIDTH-1:0]    data_in   [0:NUM_OF_ROWS-1][0:NUM_OF_COLS-1];
   logic [0:NUM_OF_COLS-1]   enable_in [0:NUM_OF_ROWS-1];
   logic [0:NUM_OF_COLS-1]   ready_out [0:NUM_OF_ROWS-1];
   logic [DATA_WIDTH-1:0]    data_out;
   logic                     data_rd_en;
   logic                     data_empty;
`ifdef GON_TIMEOUT_EN
   logic                     timeout_err;
`endif

   modport slave (
      input  row_tag, col_tag, tags_wr_en, row_id, col_id, data_in, enable_in, data_rd_en,
      output tags_full, ready_out, data_out, data_empty
`ifdef GON_TIMEOUT_EN
      , output timeout_err
`endif
   );

   modport master (
      output row_tag, col_tag, tags_wr_en, row_id, col_id, data_in, enable_in, data_rd_en,
      input  tags_full, ready_out, data_out, data_empty
`ifdef GON_TIMEOUT_EN
      , input timeout_err
`endif
   );
endinterface

// File: rtl/fifo_top.sv
// Synchronous first-word-fall-through FIFO; push is accepted when full if a pop happens in the same cycle.
module fifo_top #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             full_o,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH-1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             do_wr, do_rd;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == FULL_CNT);
   assign do_rd   = rd_en_i & ~empty_o;
   assign do_wr   = wr_en_i & (~full_o | do_rd);
   assign dout_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= din_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/gon_select.sv
// Finds the PE addressed by the current tag (lowest row, then lowest column wins) and decodes its one-hot grant.
module gon_select #(
   parameter int ROW_TAG_WIDTH = 4,
   parameter int COL_TAG_WIDTH = 4,
   parameter int NUM_OF_ROWS   = 12,
   parameter int NUM_OF_COLS   = 14,
   localparam int ROW_IDX_W    = $clog2(NUM_OF_ROWS),
   localparam int COL_IDX_W    = $clog2(NUM_OF_COLS)
) (
   input  logic [ROW_TAG_WIDTH-1:0] tag_row_i,
   input  logic [COL_TAG_WIDTH-1:0] tag_col_i,
   input  logic                     grant_en_i,
   input  logic [ROW_TAG_WIDTH-1:0] row_id_i [0:NUM_OF_ROWS-1],
   input  logic [COL_TAG_WIDTH-1:0] col_id_i [0:NUM_OF_ROWS-1][0:NUM_OF_COLS-1],
   output logic                     hit_o,
   output logic [ROW_IDX_W-1:0]     sel_row_o,
   output logic [COL_IDX_W-1:0]     sel_col_o,
   output logic [0:NUM_OF_COLS-1]   ready_o [0:NUM_OF_ROWS-1]
);
   // Scan from the top index down so the last match written is the lowest (r, c).
   always_comb begin
      hit_o     = 1'b0;
      sel_row_o = '0;
      sel_col_o = '0;
      for (int r = NUM_OF_ROWS - 1; r >= 0; r--) begin
         for (int c = NUM_OF_COLS - 1; c >= 0; c--) begin
            if (row_id_i[r] == tag_row_i && col_id_i[r][c] == tag_col_i) begin
               hit_o     = 1'b1;
               sel_row_o = ROW_IDX_W'(r);
               sel_col_o = COL_IDX_W'(c);
            end
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_OF_ROWS; r++) ready_o[r] = '0;
      if (grant_en_i && hit_o) ready_o[sel_row_o][sel_col_o] = 1'b1;
   end
endmodule

// File: rtl/gon_collector.sv
// Tag-driven gather of PE words into a host FIFO, in tag order.
// Optional GON_TIMEOUT_EN adds a WAIT watchdog that drops a stuck tag and pulses timeout_err.
//   state | meaning
//   IDLE  | no tag loaded; pops the tag FIFO head when present
//   WAIT  | tag_q loaded; granting the matching PE until it transfers
module gon_collector
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ROW_TAG_WIDTH  = DEF_ROW_TAG_WIDTH,
   parameter int COL_TAG_WIDTH  = DEF_COL_TAG_WIDTH,
   parameter int NUM_OF_ROWS    = DEF_NUM_OF_ROWS,
   parameter int NUM_OF_COLS    = DEF_NUM_OF_COLS,
   parameter int GON_FIFO_DEPTH = DEF_GON_FIFO_DEPTH
`ifdef GON_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
   input logic            clk,
   input logic            reset,
   gon_collector_if.slave bus
);
   localparam int TAG_W     = ROW_TAG_WIDTH + COL_TAG_WIDTH;
   localparam int ROW_IDX_W = $clog2(NUM_OF_ROWS);
   localparam int COL_IDX_W = $clog2(NUM_OF_COLS);

   gon_state_t           state_q;
   logic [TAG_W-1:0]     tag_q, tag_head;
   logic                 tag_empty, tag_pop, data_full;
   logic                 wait_st, grant_en, hit, xfer, tmo, adv;
   logic [ROW_IDX_W-1:0] sel_row;
   logic [COL_IDX_W-1:0] sel_col;

   fifo_top #(.WIDTH(TAG_W), .DEPTH(GON_FIFO_DEPTH)) u_tag_fifo (
      .clk(clk), .reset(reset),
      .wr_en_i(bus.tags_wr_en), .din_i({bus.col_tag, bus.row_tag}), .full_o(bus.tags_full),
      .rd_en_i(tag_pop), .dout_o(tag_head), .empty_o(tag_empty)
   );

   fifo_top #(.WIDTH(DATA_WIDTH), .DEPTH(GON_FIFO_DEPTH)) u_data_fifo (
      .clk(clk), .reset(reset),
      .wr_en_i(xfer), .din_i(bus.data_in[sel_row][sel_col]), .full_o(data_full),
      .rd_en_i(bus.data_rd_en), .dout_o(bus.data_out), .empty_o(bus.data_empty)
   );

   gon_select #(
      .ROW_TAG_WIDTH(ROW_TAG_WIDTH), .COL_TAG_WIDTH(COL_TAG_WIDTH),
      .NUM_OF_ROWS(NUM_OF_ROWS), .NUM_OF_COLS(NUM_OF_COLS)
   ) u_select (
      .tag_row_i(tag_q[ROW_TAG_WIDTH-1:0]), .tag_col_i(tag_q[TAG_W-1:ROW_TAG_WIDTH]),
      .grant_en_i(grant_en), .row_id_i(bus.row_id), .col_id_i(bus.col_id),
      .hit_o(hit), .sel_row_o(sel_row), .sel_col_o(sel_col), .ready_o(bus.ready_out)
   );

   assign wait_st  = (state_q == WAIT);
   assign grant_en = wait_st & ~data_full;
   assign xfer     = grant_en & hit & bus.enable_in[sel_row][sel_col];
   assign adv      = xfer | tmo;
   // A finished tag is replaced by the next one in the same cycle to keep one word per clock.
   assign tag_pop  = ~tag_empty & (~wait_st | adv);

`ifdef GON_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   logic [WD_W-1:0] wd_q;
   logic            terr_q;

   assign tmo             = grant_en & ~xfer & (wd_q == WD_W'(TIMEOUT_CYCLES - 2));
   assign bus.timeout_err = terr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_q   <= '0;
         terr_q <= 1'b0;
      end else begin
         terr_q <= tmo;
         if (!wait_st || adv)  wd_q <= '0;
         else if (!data_full)  wd_q <= wd_q + WD_W'(1);
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         tag_q   <= '0;
      end else if (state_q == IDLE) begin
         if (!tag_empty) begin
            tag_q   <= tag_head;
            state_q <= WAIT;
         end
      end else if (adv) begin
         if (!tag_empty) begin
            tag_q <= tag_head;
         end else begin
            tag_q   <= '0;
            state_q <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_gon_collector.sv
// Directed bench for gon_collector with a data scoreboard; GON_TIMEOUT_EN enables the watchdog scenario.
module tb_gon_collector;
   import noc_pkg::*;

   localparam int NONE = -1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;
   logic [63:0] sb [$];

   gon_collector_if bus ();

   gon_collector dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "bench time limit");
   end

   function automatic logic [63:0] pe_word(input int r, input int c);
      if (r == 2 && c == 5) return 64'hA5A5;
      return {16'hBEEF, 8'(r), 8'(c), 32'h0F0F_0000 + 32'(r * DEF_NUM_OF_COLS + c)};
   endfunction

   // Position r*16+c of the single granted PE, NONE if none, -2 if several.
   function automatic int grant_pos();
      int pos = NONE;
      int cnt = 0;
      for (int r = 0; r < DEF_NUM_OF_ROWS; r++)
         for (int c = 0; c < DEF_NUM_OF_COLS; c++)
            if (bus.ready_out[r][c] !== 1'b0) begin
               cnt++;
               pos = r * 16 + c;
            end
      return (cnt > 1) ? -2 : pos;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_grant(input string tag, input int exp);
      chk(tag, 64'(grant_pos()), 64'(exp));
   endtask

   task automatic put_tag(input int r, input int c);
      bus.row_tag    = 4'(r);
      bus.col_tag    = 4'(c);
      bus.tags_wr_en = 1'b1;
      tick();
      bus.tags_wr_en = 1'b0;
   endtask

   task automatic set_enable_all(input logic v);
      for (int r = 0; r < DEF_NUM_OF_ROWS; r++) bus.enable_in[r] = v ? '1 : '0;
   endtask

   task automatic set_default_ids();
      for (int r = 0; r < DEF_NUM_OF_ROWS; r++) begin
         bus.row_id[r] = 4'(r);
         for (int c = 0; c < DEF_NUM_OF_COLS; c++) bus.col_id[r][c] = 4'(c);
      end
   endtask

   task automatic host_read(input string tag);
      logic [63:0] exp;
      int n = 0;
      while (bus.data_empty && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_avail"}, 64'(bus.data_empty), 64'(0));
      if (sb.size() > 0) exp = sb.pop_front();
      else exp = 64'hDEAD_DEAD_DEAD_DEAD;
      chk({tag, "_data"}, bus.data_out, exp);
      bus.data_rd_en = 1'b1;
      tick();
      bus.data_rd_en = 1'b0;
   endtask

   initial begin
      int tr [4];
      int tc [4];
      int n;
      bus.row_tag    = '0;
      bus.col_tag    = '0;
      bus.tags_wr_en = 1'b0;
      bus.data_rd_en = 1'b0;
      set_default_ids();
      set_enable_all(1'b0);
      for (int r = 0; r < DEF_NUM_OF_ROWS; r++)
         for (int c = 0; c < DEF_NUM_OF_COLS; c++) bus.data_in[r][c] = pe_word(r, c);
      tick();
      tick();
      reset = 1'b0;
      tick();

      chk("rst_tags_full", 64'(bus.tags_full), 64'(0));
      chk("rst_data_empty", 64'(bus.data_empty), 64'(1));
      chk_grant("rst_ready", NONE);

      // single read, PE[2][5]
      bus.enable_in[2][5] = 1'b1;
      put_tag(2, 5);
      chk_grant("single_ready_c1", NONE);
      tick();
      chk_grant("single_ready_c2", 2 * 16 + 5);
      tick();
      chk_grant("single_ready_after", NONE);
      chk("single_empty", 64'(bus.data_empty), 64'(0));
      chk("single_peek", bus.data_out, 64'hA5A5);
      sb.push_back(64'hA5A5);
      host_read("single");
      bus.enable_in[2][5] = 1'b0;

      // back-to-back, four PEs
      tr = '{0, 5, 11, 3};
      tc = '{0, 13, 7, 2};
      for (int i = 0; i < 4; i++) begin
         put_tag(tr[i], tc[i]);
         sb.push_back(pe_word(tr[i], tc[i]));
      end
      set_enable_all(1'b1);
      for (int i = 0; i < 4; i++) begin
         chk_grant($sformatf("b2b_grant%0d", i), tr[i] * 16 + tc[i]);
         tick();
      end
      chk_grant("b2b_grant_end", NONE);
      set_enable_all(1'b0);
      for (int i = 0; i < 4; i++) host_read($sformatf("b2b_rd%0d", i));
      chk("b2b_drained", 64'(bus.data_empty), 64'(1));

      // tag FIFO full / drop, then data FIFO backpressure
      for (int i = 0; i < 17; i++) begin
         put_tag(i % 12, (i * 3) % 14);
         sb.push_back(pe_word(i % 12, (i * 3) % 14));
      end
      chk("tags_full_set", 64'(bus.tags_full), 64'(1));
      put_tag(9, 9);
      chk("tags_full_hold", 64'(bus.tags_full), 64'(1));
      set_enable_all(1'b1);
      repeat (20) tick();
      chk_grant("bp_ready_low", NONE);
      chk("bp_data_avail", 64'(bus.data_empty), 64'(0));
      chk("bp_tags_drained", 64'(bus.tags_full), 64'(0));
      host_read("bp_rd0");
      chk_grant("bp_one_more", 4 * 16 + 6);
      tick();
      chk_grant("bp_idle", NONE);
      tick();
      chk_grant("bp_idle2", NONE);
      set_enable_all(1'b0);
      for (int i = 1; i < 17; i++) host_read($sformatf("bp_rd%0d", i));
      chk("bp_drained", 64'(bus.data_empty), 64'(1));

      // multi-match: rows 3 and 7 both claim row id 3, several columns claim col id 4
      bus.row_id[7]     = 4'd3;
      bus.col_id[3][4]  = 4'd9;
      bus.col_id[3][10] = 4'd4;
      bus.col_id[3][12] = 4'd4;
      bus.col_id[7][2]  = 4'd4;
      put_tag(3, 4);
      tick();
      chk_grant("mm_grant", 3 * 16 + 10);
      bus.enable_in[7][2]  = 1'b1;
      bus.enable_in[3][10] = 1'b1;
      sb.push_back(pe_word(3, 10));
      tick();
      chk_grant("mm_done", NONE);
      host_read("mm_rd");
      chk("mm_single", 64'(bus.data_empty), 64'(1));
      set_enable_all(1'b0);
      set_default_ids();

      // reset while in WAIT with data and a queued tag present
      bus.enable_in[0][0] = 1'b1;
      put_tag(0, 0);
      tick();
      tick();
      bus.enable_in[0][0] = 1'b0;
      chk("rw_data_present", 64'(bus.data_empty), 64'(0));
      put_tag(6, 6);
      put_tag(1, 1);
      chk_grant("rw_wait_grant", 6 * 16 + 6);
      #2;
      reset = 1'b1;
      #1;
      chk_grant("rw_ready_async", NONE);
      chk("rw_empty_async", 64'(bus.data_empty), 64'(1));
      chk("rw_full_async", 64'(bus.tags_full), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      tick();
      tick();
      bus.enable_in[1][1] = 1'b1;
      bus.enable_in[6][6] = 1'b1;
      repeat (3) tick();
      chk_grant("rw_after_ready", NONE);
      chk("rw_after_empty", 64'(bus.data_empty), 64'(1));
      set_enable_all(1'b0);

`ifdef GON_TIMEOUT_EN
      // silent PE[9][9] times out, then PE[4][4] is served
      bus.enable_in[4][4] = 1'b1;
      put_tag(9, 9);
      put_tag(4, 4);
      sb.push_back(pe_word(4, 4));
      chk_grant("to_wait_grant", 9 * 16 + 9);
      n = 1;
      while (bus.timeout_err !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      chk("to_cycle", 64'(n), 64'(256));
      chk("to_no_data", 64'(bus.data_empty), 64'(1));
      chk_grant("to_next_grant", 4 * 16 + 4);
      tick();
      chk("to_pulse_end", 64'(bus.timeout_err), 64'(0));
      host_read("to_rd");
      set_enable_all(1'b0);
`endif

      chk("final_empty", 64'(bus.data_empty), 64'(1));
      n = sb.size();
      chk("final_sb_empty", 64'(n), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
